uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
UART transmitter that frames a parallel byte into a serial line: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit. It is the transmit counterpart of the oversampled UART receiver and runs on the same oversampled clock, so each bit lasts OVERSAMPLE CLK cycles. It accepts data through a valid/busy handshake and supports back-to-back frames with no idle gap.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
OVERSAMPLE, 8, CLK cycles per serial bit; must be ≥2

Ports:
CLK  in  1  oversampled clock
RST  in  1  asynchronous reset, active-low
P_Data  in  DATA_WIDTH  parallel byte to send
Data_Valid  in  1  P_Data valid; sampled only when the block is ready to accept
Parity_Enable  in  1  1 = insert parity bit
Parity_Type  in  1  0 = even, 1 = odd
TX_OUT  out  1  serial line, idle high
Busy  out  1  frame in progress; Data_Valid is ignored while Busy=1, except at the final stop cycle

Behaviour:
- Reset is asynchronous, active-low, reset RST, clock CLK.
- Reset values: TX_OUT=1, Busy=0, state=IDLE, counters=0, shift register=0.
- Reset mid-frame aborts the frame immediately: TX_OUT=1, Busy=0. There is no resume.
- All outputs are registered. There is no combinational path from any input to TX_OUT or Busy.
- States: IDLE, START, DATA, PARITY, STOP.
- Internal Edge_Count runs 0..OVERSAMPLE-1 and increments every cycle outside IDLE. Bit_Count runs 0..DATA_WIDTH-1.
- A bit ends on the cycle where Edge_Count=OVERSAMPLE-1. On that edge Edge_Count wraps to 0 and the next bit starts.
- IDLE: TX_OUT=1, Busy=0. If Data_Valid=1 at a CLK edge, the following happen on that edge:
  - P_Data, Parity_Enable and Parity_Type are latched.
  - Parity is computed: even = XOR of the bits; odd = XNOR of the bits.
  - State goes to START, TX_OUT goes to 0, Busy goes to 1.
  - Latency is 1 cycle from the accepting edge to the start bit appearing.
- START: TX_OUT=0 for OVERSAMPLE cycles, then DATA.
- DATA: TX_OUT = shift register bit 0, LSB first. The register shifts right at each bit end. After bit DATA_WIDTH-1 the next state is PARITY if the latched Parity_Enable=1, otherwise STOP.
- PARITY: TX_OUT = latched parity bit for OVERSAMPLE cycles, then STOP.
- STOP: TX_OUT=1 for OVERSAMPLE cycles. At the final stop cycle (Edge_Count=OVERSAMPLE-1):
  - If Data_Valid=1: accept new data exactly as in IDLE and go to START. Busy stays 1 and TX_OUT goes 0 on the next cycle (back-to-back, no gap).
  - Else: go to IDLE, Busy goes 0.
- Frame length: (2 + DATA_WIDTH + Parity_Enable) × OVERSAMPLE cycles. Busy=1 for exactly that many cycles per frame.
- Changes to P_Data, Parity_Enable or Parity_Type mid-frame have no effect on the current frame.
- Data_Valid pulses during a frame, other than at the final stop cycle, are dropped. There is no queueing.
- Undefined state encodings recover to IDLE with TX_OUT=1.

Decomposition:
- Shared package: state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) and parity type constants (EVEN=0, ODD=1). These are shared with the receiver FSM.
- One sub-module, uart_tx_serializer. It holds the load/shift register and Bit_Count, and is driven by load and shift strobes from the FSM.
- Parity calculation and the output mux stay in the top level.

Test Plan:
All cases use DATA_WIDTH=8 and OVERSAMPLE=8.
1. Reset: hold RST=0 with random inputs -> TX_OUT=1, Busy=0. Release, keep Data_Valid=0 for 100 cycles -> TX_OUT stays 1.
2. No parity: P_Data=0xA5, Parity_Enable=0, 1-cycle Data_Valid pulse -> TX_OUT is 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles. Busy=1 for exactly 80 cycles. Start bit appears 1 cycle after the accepting edge.
3. Parity: P_Data=0xA5, Parity_Enable=1, Parity_Type=0 -> parity bit 0, frame 88 cycles. Repeat with Parity_Type=1 -> parity bit 1. Repeat with P_Data=0x07, even -> parity bit 1.
4. Back-to-back: hold Data_Valid=1 with P_Data=0x3C, then switch P_Data to 0xC3 during the first stop bit -> stop bit is exactly 8 cycles, the second start bit follows immediately, Busy never drops, and the second frame carries 0xC3.
5. Mid-frame interference: during the DATA bits of a 0x00 frame, pulse Data_Valid with P_Data=0xFF and toggle Parity_Type -> the frame remains 0x00 with its original parity, and no second frame is sent.
6. Reset mid-frame: assert RST=0 during data bit 3 -> TX_OUT=1 and Busy=0 immediately, without waiting for a clock edge. A fresh 0x5A frame sent afterwards is bit-exact.

Source files
------------

// File: rtl/uart_tx_frame_pkg.sv
// Shared UART encodings: FSM states and parity types,
// common to the transmitter and the receiver.
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_type_e;

  // Even parity is the XOR of the data bits; odd is its complement.
  function automatic logic par_bit(
    input logic data_xor,
    input logic ptype
  );
    return data_xor ^ (ptype == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_frame_serializer.sv
// Load/shift register and bit counter for the UART transmitter.
// Presents the current and next data bit so TX_OUT can stay registered.
module uart_tx_serializer
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  cur_bit_o,
  output logic                  nxt_bit_o,
  output logic                  last_o
);

  localparam int CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_shr;
  logic [CW-1:0]         cnt_q, cnt_d;

  assign sr_shr    = sr_q >> 1;
  assign cur_bit_o = sr_q[0];
  assign nxt_bit_o = sr_shr[0];
  assign last_o    = (cnt_q == CNT_LAST);

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      load_i: begin
        sr_d  = data_i;
        cnt_d = '0;
      end
      shift_i: begin
        sr_d  = sr_shr;
        cnt_d = last_o ? '0 : cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, LSB-first data, optional parity, one stop,
// each bit OVERSAMPLE clocks; back-to-back frames with no idle gap.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int EW =
    (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);

  tx_state_e     state_q;
  logic [EW-1:0] edge_q;
  logic          tx_q;
  logic          busy_q;
  logic          par_en_q;
  logic          par_q;

  logic edge_last;
  logic accept;
  logic shift;
  logic cur_bit;
  logic nxt_bit;
  logic last_bit;

  assign edge_last = (edge_q == EDGE_LAST);
  assign shift     = (state_q == DATA) & edge_last;
  // Accept in IDLE, or on the last stop cycle for gapless chaining.
  assign accept    = Data_Valid &
                     ((state_q == IDLE) |
                      ((state_q == STOP) & edge_last));

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load_i    (accept),
    .shift_i   (shift),
    .data_i    (P_Data),
    .cur_bit_o (cur_bit),
    .nxt_bit_o (nxt_bit),
    .last_o    (last_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      edge_q   <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      edge_q <= edge_last ? '0 : edge_q + 1'b1;
      if (accept) begin
        state_q  <= START;
        edge_q   <= '0;
        tx_q     <= 1'b0;
        busy_q   <= 1'b1;
        par_en_q <= Parity_Enable;
        par_q    <= par_bit(^P_Data, Parity_Type);
      end else begin
        unique case (state_q)
          IDLE: begin
            edge_q <= '0;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
          START: if (edge_last) begin
            state_q <= DATA;
            tx_q    <= cur_bit;
          end
          DATA: if (edge_last) begin
            if (!last_bit) begin
              tx_q <= nxt_bit;
            end else if (par_en_q) begin
              state_q <= PARITY;
              tx_q    <= par_q;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end
          PARITY: if (edge_last) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
          STOP: if (edge_last) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            edge_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: frames are predicted as bit lists
// expanded to OVERSAMPLE cycles each.
module tb_uart_tx_frame;

  localparam int OS = 8;

  typedef bit bitq_t[$];

  logic       CLK;
  logic       RST;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       Parity_Enable;
  logic       Parity_Type;
  logic       TX_OUT;
  logic       Busy;

  int vectors;
  int miscompares;

  uart_tx_frame #(
    .DATA_WIDTH(8),
    .OVERSAMPLE(OS)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .P_Data        (P_Data),
    .Data_Valid    (Data_Valid),
    .Parity_Enable (Parity_Enable),
    .Parity_Type   (Parity_Type),
    .TX_OUT        (TX_OUT),
    .Busy          (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Serial bit sequence of one frame, one entry per bit period.
  function automatic bitq_t frame_bits(
    input bit [7:0] d,
    input bit       pe,
    input bit       pt
  );
    bitq_t q;
    int    ones;
    ones = $countones(d);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pe) q.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    q.push_back(1'b1);
    return q;
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      P_Data        = 8'($urandom);
      Data_Valid    = 1'($urandom);
      Parity_Enable = 1'($urandom);
      Parity_Type   = 1'($urandom);
      step();
      vectors++;
      if ({TX_OUT, Busy} !== 2'b10) begin
        miscompares++;
        $display("FAIL reset_hold: TX_OUT,Busy=%b%b want 10",
                 TX_OUT, Busy);
      end
    end
    Data_Valid = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 100; i++) begin
      P_Data = 8'($urandom);
      step();
      vectors++;
      if ({TX_OUT, Busy} !== 2'b10) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: TX_OUT,Busy=%b%b want 10",
                 i, TX_OUT, Busy);
      end
    end
  endtask

  task automatic test_single(
    input bit [7:0] d,
    input bit       pe,
    input bit       pt,
    input bit       exp_par,
    input string    nm
  );
    bitq_t q;
    int    n;
    q = frame_bits(d, pe, pt);
    n = q.size() * OS;
    vectors++;
    if ({TX_OUT, Busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL %s pre_idle: TX_OUT,Busy=%b%b want 10",
               nm, TX_OUT, Busy);
    end
    P_Data = d; Parity_Enable = pe; Parity_Type = pt;
    Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      vectors++;
      if ({TX_OUT, Busy} !== {q[k / OS], 1'b1}) begin
        miscompares++;
        $display("FAIL %s cyc %0d: TX_OUT,Busy=%b%b want %b1",
                 nm, k, TX_OUT, Busy, q[k / OS]);
      end
      if (pe && k == 9 * OS + OS / 2) begin
        vectors++;
        if (TX_OUT !== exp_par) begin
          miscompares++;
          $display("FAIL %s parity: got %b want %b",
                   nm, TX_OUT, exp_par);
        end
      end
      step();
    end
    vectors++;
    if ({TX_OUT, Busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL %s end: TX_OUT,Busy=%b%b want 10",
               nm, TX_OUT, Busy);
    end
  endtask

  task automatic test_back_to_back();
    bitq_t q;
    int    n;
    q = {frame_bits(8'h3C, 1'b0, 1'b0),
         frame_bits(8'hC3, 1'b0, 1'b0)};
    n = q.size() * OS;
    P_Data = 8'h3C; Parity_Enable = 1'b0; Parity_Type = 1'b0;
    Data_Valid = 1'b1;
    step();
    for (int k = 0; k < n; k++) begin
      vectors++;
      if ({TX_OUT, Busy} !== {q[k / OS], 1'b1}) begin
        miscompares++;
        $display("FAIL b2b cyc %0d: TX_OUT,Busy=%b%b want %b1",
                 k, TX_OUT, Busy, q[k / OS]);
      end
      if (k == 9 * OS) P_Data = 8'hC3;
      if (k == 10 * OS) Data_Valid = 1'b0;
      step();
    end
    vectors++;
    if ({TX_OUT, Busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b end: TX_OUT,Busy=%b%b want 10", TX_OUT, Busy);
    end
  endtask

  task automatic test_interference();
    bitq_t q;
    int    n;
    q = frame_bits(8'h00, 1'b1, 1'b0);
    n = q.size() * OS;
    P_Data = 8'h00; Parity_Enable = 1'b1; Parity_Type = 1'b0;
    Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      vectors++;
      if ({TX_OUT, Busy} !== {q[k / OS], 1'b1}) begin
        miscompares++;
        $display("FAIL interf cyc %0d: TX_OUT,Busy=%b%b want %b1",
                 k, TX_OUT, Busy, q[k / OS]);
      end
      if (k == 20) begin
        Data_Valid = 1'b1; P_Data = 8'hFF; Parity_Type = 1'b1;
      end
      if (k == 21) Data_Valid = 1'b0;
      step();
    end
    for (int i = 0; i < 2 * OS; i++) begin
      vectors++;
      if ({TX_OUT, Busy} !== 2'b10) begin
        miscompares++;
        $display("FAIL interf idle %0d: TX_OUT,Busy=%b%b want 10",
                 i, TX_OUT, Busy);
      end
      step();
    end
    Parity_Type = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bitq_t q;
    q = frame_bits(8'h96, 1'b0, 1'b0);
    P_Data = 8'h96; Parity_Enable = 1'b0; Parity_Type = 1'b0;
    Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    for (int k = 0; k <= 4 * OS + 3; k++) begin
      vectors++;
      if ({TX_OUT, Busy} !== {q[k / OS], 1'b1}) begin
        miscompares++;
        $display("FAIL rstmid cyc %0d: TX_OUT,Busy=%b%b want %b1",
                 k, TX_OUT, Busy, q[k / OS]);
      end
      if (k < 4 * OS + 3) step();
    end
    #2;
    RST = 1'b0;
    #1;
    vectors++;
    if ({TX_OUT, Busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL rstmid async: TX_OUT,Busy=%b%b want 10",
               TX_OUT, Busy);
    end
    step();
    step();
    RST = 1'b1;
    step();
    test_single(8'h5A, 1'b0, 1'b0, 1'b0, "post_rst");
  endtask

  task automatic test_random();
    bit [7:0] d, nd;
    bit       pe, pt, npe, npt, chain;
    bitq_t    q;
    int       n, gap;
    d = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom);
    P_Data = d; Parity_Enable = pe; Parity_Type = pt;
    Data_Valid = 1'b1;
    step();
    for (int f = 0; f < 12; f++) begin
      q = frame_bits(d, pe, pt);
      n = q.size() * OS;
      chain = (f < 11) && ($urandom_range(0, 1) == 1);
      nd = 8'($urandom); npe = 1'($urandom); npt = 1'($urandom);
      for (int k = 0; k < n; k++) begin
        vectors++;
        if ({TX_OUT, Busy} !== {q[k / OS], 1'b1}) begin
          miscompares++;
          $display("FAIL rnd f%0d d=%h cyc %0d: TX_OUT,Busy=%b%b want %b1",
                   f, d, k, TX_OUT, Busy, q[k / OS]);
        end
        if (k == n - 1) begin
          Data_Valid = chain;
          P_Data = nd; Parity_Enable = npe; Parity_Type = npt;
        end else begin
          Data_Valid    = 1'($urandom);
          P_Data        = 8'($urandom);
          Parity_Enable = 1'($urandom);
          Parity_Type   = 1'($urandom);
        end
        step();
      end
      if (!chain) begin
        gap = $urandom_range(1, 5);
        Data_Valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
          vectors++;
          if ({TX_OUT, Busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL rnd f%0d gap %0d: TX_OUT,Busy=%b%b want 10",
                     f, i, TX_OUT, Busy);
          end
          if (i == gap - 1 && f < 11) begin
            Data_Valid = 1'b1;
            P_Data = nd; Parity_Enable = npe; Parity_Type = npt;
          end else begin
            P_Data = 8'($urandom);
          end
          step();
        end
      end
      d = nd; pe = npe; pt = npt;
    end
    Data_Valid = 1'b0;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    RST           = 1'b0;
    P_Data        = 8'h00;
    Data_Valid    = 1'b0;
    Parity_Enable = 1'b0;
    Parity_Type   = 1'b0;
    test_reset();
    test_single(8'hA5, 1'b0, 1'b0, 1'b0, "nopar_a5");
    test_single(8'hA5, 1'b1, 1'b0, 1'b0, "even_a5");
    test_single(8'hA5, 1'b1, 1'b1, 1'b1, "odd_a5");
    test_single(8'h07, 1'b1, 1'b0, 1'b1, "even_07");
    test_back_to_back();
    test_interference();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
